instruction_encoder: RTL
========================

# instruction_encoder

Program-memory writer for the 8-bit teaching processor: accepts one symbolic operation per handshake and encodes it into the 8-bit instruction format consumed by the instruction decoder. It writes the encoded byte into program memory through a synchronous write port. Sequential address generation, NOP padding of the remaining memory, and a full/rewind protocol allow a test sequencer or loader to build programs in place ahead of processor release from reset.

## Interface
- ADDR_W, 8, program memory address width; depth = 2^ADDR_W
- NOP_BYTE, 8'hCF, byte written by fill and by unknown ops when checking is compiled out

- clk  in  1  system clock
- sync_reset  in  1  synchronous, active-high reset
- req_valid  in  1  operation request present
- req_ready  out  1  encoder accepts request this cycle
- op  in  3  0 load, 1 mov, 2 alu, 3 jmp, 4 jmp_nz, 5 nop, 6/7 unused
- dst  in  3  load/mov destination (0 x0, 1 x1, 2 y0, 3 y1, 4 o_reg, 5 m, 6 i, 7 dm)
- src  in  3  mov source
- imm  in  4  load immediate / jump target nibble
- x_sel, y_sel  in  1 each  alu operand selects
- alu_fn  in  3  alu function
- fill_req  in  1  pad from current address to last location with NOP_BYTE
- rewind  in  1  return write address to 0
- pm_we  out  1  program memory write strobe
- pm_addr  out  ADDR_W  write address
- pm_data  out  8  encoded instruction byte
- full  out  1  last location written
- err  out  1  one-cycle pulse: rejected request

## Operation
- Encoding (op -> pm_data): load {1'b0,dst,imm}; mov {2'b10,dst,src}; alu {3'b110,x_sel,y_sel,alu_fn}; jmp {4'hE,imm}; jmp_nz {4'hF,imm}; nop NOP_BYTE.
- mov with dst==src is legal and encoded verbatim (decoder treats it as i_pins/r source).
- Internal write pointer wp (ADDR_W bits). Every write uses pm_addr=wp, then wp increments.
- States: IDLE, FILL, FULL.
  - IDLE: req_ready=1. Accepted request (req_valid&req_ready) writes one byte. fill_req with no accepted request -> FILL. Write to location 2^ADDR_W-1 -> FULL.
  - FILL: req_ready=0; writes NOP_BYTE every cycle; write to last location -> FULL.
  - FULL: req_ready=0, full=1, no writes; pointer does not wrap.
- rewind (any state): wp=0, state IDLE, full=0, no write that cycle; overrides req_valid and fill_req.
- req_valid and fill_req same cycle in IDLE: request written, fill_req ignored (must be reasserted).
- fill_req in FILL/FULL ignored.

## Timing
- Reset values: req_ready 0 during reset cycle, 1 the cycle after; pm_we 0, pm_addr 0, pm_data 8'h00, full 0, err 0; wp 0; state IDLE.
- pm_we/pm_addr/pm_data registered: visible the cycle after acceptance, one-cycle strobe; pm_data/pm_addr hold last value when pm_we=0.
- Throughput: one request per cycle in IDLE; FILL writes one byte per cycle.
- full asserts the cycle after the last write's strobe; req_ready drops the same cycle.
- sync_reset mid-FILL aborts fill; no write in the reset cycle.
- err registered, one cycle after the offending accept.

## Configuration
- ENCODER_OP_CHECK_EN defined: op 6/7 accepted (handshake completes) but not written, wp unchanged, err pulses.
- Undefined: op 6/7 written as NOP_BYTE, wp advances, err tied 0.

## Test plan
- Reset, then load dst=5 imm=4'hA -> cycle after accept pm_we=1, pm_addr=0, pm_data=8'h5A; next request at pm_addr=1.
- Back-to-back mov dst=4 src=4, alu x=1 y=0 fn=3, jmp imm=3, jmp_nz imm=C -> pm_data 8'hA4, 8'hD3, 8'hE3, 8'hFC at addresses 0-3 on consecutive cycles.
- Write 3 ops then fill_req -> NOP_BYTE 8'hCF at addresses 3..8'hFF, 253 consecutive strobes; full=1; req_valid ignored afterwards.
- In FULL, pulse rewind -> full=0, req_ready=1; next load x0 imm=1 writes 8'h01 at address 0.
- Same-cycle req_valid and fill_req in IDLE -> only request written, state stays IDLE; sync_reset asserted during FILL -> pm_we=0 next cycle, pm_addr=0.
- op=6 with ENCODER_OP_CHECK_EN -> err pulse, no pm_we, wp unchanged; without it -> 8'hCF written, err=0.

Source files
------------

// File: rtl/instruction_encoder_if.sv
// Request/program-memory bundle for instruction_encoder.
// The master (test sequencer or loader) issues symbolic operations and fill/rewind
// controls. The slave (encoder) returns the handshake, memory write port and status.
interface instruction_encoder_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        op;
    logic [2:0]        dst;
    logic [2:0]        src;
    logic [3:0]        imm;
    logic              x_sel;
    logic              y_sel;
    logic [2:0]        alu_fn;
    logic              fill_req;
    logic              rewind;
    logic              pm_we;
    logic [ADDR_W-1:0] pm_addr;
    logic [7:0]        pm_data;
    logic              full;
    logic              err;

    modport master (
        output req_valid, op, dst, src, imm, x_sel, y_sel, alu_fn, fill_req, rewind,
        input  req_ready, pm_we, pm_addr, pm_data, full, err
    );

    modport slave (
        input  req_valid, op, dst, src, imm, x_sel, y_sel, alu_fn, fill_req, rewind,
        output req_ready, pm_we, pm_addr, pm_data, full, err
    );
endinterface

// File: rtl/instruction_encoder.sv
// instruction_encoder: encodes one symbolic operation per handshake into the 8-bit
// instruction format and writes it to program memory at a sequential address.
// The encoder can also pad the rest of memory with NOP_BYTE, and supports a
// full/rewind protocol.
// Optional feature macro: ENCODER_OP_CHECK_EN. When it is defined, ops 6/7 are
// accepted but not written, and err pulses.
module instruction_encoder #(
    parameter int unsigned ADDR_W   = 8,
    parameter logic [7:0]  NOP_BYTE = 8'hCF
) (
    input  logic                  clk,
    input  logic                  sync_reset,
    instruction_encoder_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_FULL
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_wp;
    logic [ADDR_W-1:0] r_pm_addr;
    logic [7:0]        r_pm_data;
    logic              r_pm_we;
    logic              r_req_ready;
    logic              r_full;
`ifdef ENCODER_OP_CHECK_EN
    logic              r_err;
    logic              w_unused_op;
`endif

    logic              w_accept;
    logic              w_last;
    logic [7:0]        w_enc;

    // req_ready is only ever 1 in IDLE, so it alone qualifies acceptance.
    assign w_accept = bus.req_valid & r_req_ready;
    assign w_last   = (r_wp == {ADDR_W{1'b1}});
`ifdef ENCODER_OP_CHECK_EN
    assign w_unused_op = bus.op[2] & bus.op[1];
`endif

    // Translate the symbolic request into the decoder's instruction byte.
    always_comb begin
        w_enc = NOP_BYTE;
        case (bus.op)
            3'd0:    w_enc = {1'b0, bus.dst, bus.imm};
            3'd1:    w_enc = {2'b10, bus.dst, bus.src};
            3'd2:    w_enc = {3'b110, bus.x_sel, bus.y_sel, bus.alu_fn};
            3'd3:    w_enc = {4'hE, bus.imm};
            3'd4:    w_enc = {4'hF, bus.imm};
            default: w_enc = NOP_BYTE;
        endcase
    end

    // Control FSM plus the registered write port and status outputs.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            r_state     <= ST_IDLE;
            r_wp        <= '0;
            r_pm_we     <= 1'b0;
            r_pm_addr   <= '0;
            r_pm_data   <= 8'h00;
            r_req_ready <= 1'b0;
            r_full      <= 1'b0;
`ifdef ENCODER_OP_CHECK_EN
            r_err       <= 1'b0;
`endif
        end else begin
            r_pm_we <= 1'b0;
`ifdef ENCODER_OP_CHECK_EN
            r_err   <= 1'b0;
`endif
            if (bus.rewind) begin
                // Rewind wins over everything and suppresses this cycle's write.
                r_state     <= ST_IDLE;
                r_wp        <= '0;
                r_full      <= 1'b0;
                r_req_ready <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_req_ready <= 1'b1;
                        if (w_accept) begin
`ifdef ENCODER_OP_CHECK_EN
                            if (w_unused_op) begin
                                r_err <= 1'b1;
                            end else begin
`endif
                                r_pm_we   <= 1'b1;
                                r_pm_addr <= r_wp;
                                r_pm_data <= w_enc;
                                if (w_last) begin
                                    r_state     <= ST_FULL;
                                    r_full      <= 1'b1;
                                    r_req_ready <= 1'b0;
                                end else begin
                                    r_wp <= r_wp + ADDR_W'(1);
                                end
`ifdef ENCODER_OP_CHECK_EN
                            end
`endif
                        end else if (bus.fill_req) begin
                            r_state     <= ST_FILL;
                            r_req_ready <= 1'b0;
                        end
                    end
                    ST_FILL: begin
                        r_req_ready <= 1'b0;
                        r_pm_we     <= 1'b1;
                        r_pm_addr   <= r_wp;
                        r_pm_data   <= NOP_BYTE;
                        if (w_last) begin
                            r_state <= ST_FULL;
                            r_full  <= 1'b1;
                        end else begin
                            r_wp <= r_wp + ADDR_W'(1);
                        end
                    end
                    ST_FULL: begin
                        r_req_ready <= 1'b0;
                        r_full      <= 1'b1;
                    end
                    default: begin
                        r_state     <= ST_IDLE;
                        r_req_ready <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.pm_we     = r_pm_we;
    assign bus.pm_addr   = r_pm_addr;
    assign bus.pm_data   = r_pm_data;
    assign bus.full      = r_full;
`ifdef ENCODER_OP_CHECK_EN
    assign bus.err       = r_err;
`else
    assign bus.err       = 1'b0;
`endif

endmodule
